// File: rtl/sudoku_pkg.sv
// Shared types and board geometry for the sudoku board RAM arbiter.
package sudoku_pkg;

  localparam int ROWS   = 4;
  localparam int CELL_W = 4;
  localparam int ROW_W  = 16;
  localparam int ADDR_W = 2;

  // Which requester, if any, owns the read returning from the RAM next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_K    = 2'd2
  } owner_t;

endpackage

// File: rtl/sudoku_streak_limiter.sv
// Priority decision between controller and checker with a streak limiter:
// the controller wins ties until it has taken MAX_STREAK grants in a row
// while the checker waited, then the checker is served once.
module sudoku_streak_limiter #(
  parameter int MAX_STREAK = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic c_req,
  input  logic k_req,
  output logic sel_c,
  output logic sel_k
);
  import sudoku_pkg::*;

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] LIMIT = SW'(MAX_STREAK);

  logic [SW-1:0] streak;

  // Grant decision; no grants while reset is asserted.
  always_comb begin
    sel_c = RST && c_req && (!k_req || (streak < LIMIT));
    sel_k = RST && k_req && !sel_c;
  end

  // Count controller wins against a waiting checker; any checker grant or idle checker clears.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      streak <= '0;
    end else if (!k_req || sel_k) begin
      streak <= '0;
    end else if (sel_c && (streak < LIMIT)) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/sudoku_ram_arbiter.sv
// Single-port board RAM arbiter: controller (read/write, priority) versus
// checker (read-only background scan). Steers read data back to the owner
// one cycle after the grant and counts controller writes as a board epoch.
module sudoku_ram_arbiter #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 16,
  parameter int MAX_STREAK = 3,
  parameter int EPOCH_W    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              k_req,
  input  logic [ADDR_W-1:0] k_addr,
  output logic              k_gnt,
  output logic              k_rvalid,
  output logic [DATA_W-1:0] k_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [EPOCH_W-1:0] epoch,
  output logic              busy_c
);
  import sudoku_pkg::*;

  logic              sel_c;
  logic              sel_k;
  logic [ADDR_W-1:0] addr_q;
  owner_t            rd_owner;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] k_rdata_q;

  sudoku_streak_limiter #(
    .MAX_STREAK(MAX_STREAK)
  ) u_limiter (
    .CLK  (CLK),
    .RST  (RST),
    .c_req(c_req),
    .k_req(k_req),
    .sel_c(sel_c),
    .sel_k(sel_k)
  );

  assign c_gnt  = sel_c;
  assign k_gnt  = sel_k;
  assign busy_c = sel_c;

  // Drive the RAM from the granted requester; address parks on its last value when idle.
  always_comb begin
    ram_addr  = addr_q;
    ram_wren  = 1'b0;
    ram_wdata = '0;
    if (sel_c) begin
      ram_addr  = c_addr;
      ram_wren  = c_we;
      ram_wdata = c_wdata;
    end else if (sel_k) begin
      ram_addr  = k_addr;
    end
  end

  // Read data is live from the RAM in the return cycle and held afterwards.
  always_comb begin
    c_rvalid = (rd_owner == OWN_C);
    k_rvalid = (rd_owner == OWN_K);
    c_rdata  = c_rvalid ? ram_q : c_rdata_q;
    k_rdata  = k_rvalid ? ram_q : k_rdata_q;
  end

  // Address shadow so an idle RAM sees a stable address.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q <= '0;
    end else begin
      addr_q <= ram_addr;
    end
  end

  // Remember who issued this cycle's read; reset drops any read in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_owner <= OWN_NONE;
    end else if (sel_c && !c_we) begin
      rd_owner <= OWN_C;
    end else if (sel_k) begin
      rd_owner <= OWN_K;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  // Capture returning read data per owner so it holds until that owner's next read.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      c_rdata_q <= '0;
      k_rdata_q <= '0;
    end else begin
      if (c_rvalid) c_rdata_q <= ram_q;
      if (k_rvalid) k_rdata_q <= ram_q;
    end
  end

  // Board epoch advances on every granted controller write, wrapping naturally.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      epoch <= '0;
    end else if (sel_c && c_we) begin
      epoch <= epoch + 1'b1;
    end
  end

endmodule

// File: tb/tb_sudoku_ram_arbiter.sv
// Directed bench for sudoku_ram_arbiter with a write-first 1-cycle RAM model.
module tb_sudoku_ram_arbiter;

  logic        CLK;
  logic        RST;
  logic        c_req, c_we;
  logic [1:0]  c_addr;
  logic [15:0] c_wdata;
  logic        c_gnt, c_rvalid;
  logic [15:0] c_rdata;
  logic        k_req;
  logic [1:0]  k_addr;
  logic        k_gnt, k_rvalid;
  logic [15:0] k_rdata;
  logic [1:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_wren;
  logic [15:0] ram_q = '0;
  logic [3:0]  epoch;
  logic        busy_c;

  logic [15:0] mem [4] = '{16'h0000, 16'h0000, 16'h1234, 16'hABCD};

  int n_cmp = 0;
  int n_err = 0;
  int wren_cnt;
  int crv_cnt;

  sudoku_ram_arbiter #(
    .ADDR_W(2), .DATA_W(16), .MAX_STREAK(3), .EPOCH_W(4)
  ) dut (
    .CLK(CLK), .RST(RST),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .k_req(k_req), .k_addr(k_addr),
    .k_gnt(k_gnt), .k_rvalid(k_rvalid), .k_rdata(k_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
    .epoch(epoch), .busy_c(busy_c)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Write-first synchronous single-port RAM.
  always @(posedge CLK) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_q <= ram_wren ? ram_wdata : mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset held with both requesting and a write pending.
    RST = 1'b0; c_req = 1'b1; k_req = 1'b1; c_we = 1'b1;
    c_addr = 2'd0; c_wdata = 16'hFFFF; k_addr = 2'd0;
    #12;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_k_gnt", k_gnt, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_epoch", epoch, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_k_rvalid", k_rvalid, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_busy", busy_c, 0);
    RST = 1'b1;
    #1;
    chk("rel_c_gnt", c_gnt, 1);
    chk("rel_k_gnt", k_gnt, 0);
    chk("rel_busy", busy_c, 1);
    c_req = 1'b0; k_req = 1'b0; c_we = 1'b0;
    tick();

    // Controller read of row 2.
    c_req = 1'b1; c_we = 1'b0; c_addr = 2'd2;
    #1;
    chk("crd_gnt", c_gnt, 1);
    chk("crd_addr", ram_addr, 2);
    chk("crd_wren", ram_wren, 0);
    tick();
    c_req = 1'b0; c_addr = 2'd0;
    #1;
    chk("crd_rvalid", c_rvalid, 1);
    chk("crd_rdata", c_rdata, 16'h1234);
    chk("crd_k_rvalid", k_rvalid, 0);
    chk("idle_addr_hold", ram_addr, 2);
    chk("idle_wdata", ram_wdata, 0);
    tick();
    chk("crd_pulse", c_rvalid, 0);
    chk("crd_hold", c_rdata, 16'h1234);

    // Both requesting continuously: C,C,C,K repeating.
    c_req = 1'b1; c_we = 1'b0; c_addr = 2'd0; k_req = 1'b1; k_addr = 2'd3;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("starve_c_gnt%0d", i), c_gnt, 32'((i % 4) != 3));
      chk($sformatf("starve_k_gnt%0d", i), k_gnt, 32'((i % 4) == 3));
      chk($sformatf("starve_k_rv%0d", i), k_rvalid, 32'(i >= 1 && ((i - 1) % 4) == 3));
      if (i == 4) chk("starve_k_rdata", k_rdata, 16'hABCD);
      tick();
    end
    c_req = 1'b0; k_req = 1'b0;
    #1;
    chk("starve_last_k_rv", k_rvalid, 1);
    chk("starve_last_k_rdata", k_rdata, 16'hABCD);
    tick();

    // 17 controller writes: epoch wraps to 1.
    wren_cnt = 0; crv_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      c_req = 1'b1; c_we = 1'b1; c_addr = 2'd0; c_wdata = 16'h0100 + 16'(i);
      #1;
      if (ram_wren) wren_cnt++;
      if (c_rvalid) crv_cnt++;
      if (i == 0) chk("wr_wdata", ram_wdata, 16'h0100);
      if (i == 16) chk("wr_epoch16", epoch, 0);
      tick();
    end
    c_req = 1'b0; c_we = 1'b0;
    #1;
    if (c_rvalid) crv_cnt++;
    chk("wr_epoch_final", epoch, 1);
    chk("wr_wren_cnt", wren_cnt, 17);
    chk("wr_no_rvalid", crv_cnt, 0);
    chk("wr_idle_wren", ram_wren, 0);
    tick();

    // Read-after-write: controller writes row 1, checker reads it next cycle.
    c_req = 1'b1; c_we = 1'b1; c_addr = 2'd1; c_wdata = 16'h4321;
    #1;
    chk("raw_c_gnt", c_gnt, 1);
    tick();
    c_req = 1'b0; c_we = 1'b0; k_req = 1'b1; k_addr = 2'd1;
    #1;
    chk("raw_k_gnt", k_gnt, 1);
    chk("raw_addr", ram_addr, 1);
    chk("raw_wren", ram_wren, 0);
    tick();
    k_req = 1'b0;
    #1;
    chk("raw_k_rvalid", k_rvalid, 1);
    chk("raw_k_rdata", k_rdata, 16'h4321);
    chk("raw_epoch", epoch, 2);
    tick();

    // Async reset while a checker read is being granted.
    c_req = 1'b1; c_we = 1'b0; c_addr = 2'd0; k_req = 1'b1; k_addr = 2'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mr_c_gnt%0d", i), c_gnt, 1);
      tick();
    end
    #1;
    chk("mr_k_gnt", k_gnt, 1);
    #2;
    RST = 1'b0;
    #1;
    chk("mr_rst_k_gnt", k_gnt, 0);
    chk("mr_rst_c_gnt", c_gnt, 0);
    tick();
    chk("mr_k_rvalid", k_rvalid, 0);
    chk("mr_epoch", epoch, 0);
    chk("mr_k_rdata", k_rdata, 0);
    chk("mr_c_rdata", c_rdata, 0);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mr_post_c_gnt%0d", i), c_gnt, 32'(i != 3));
      chk($sformatf("mr_post_k_gnt%0d", i), k_gnt, 32'(i == 3));
      tick();
    end
    c_req = 1'b0; k_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sudoku_ram_arbiter.md
Name: sudoku_ram_arbiter

Overview:
Arbitrates single-port access to the sudoku board RAM between two requesters: the interface controller (read/write, latency-sensitive) and the game checker (read-only, background scan). The controller has priority, and a streak limiter guarantees the checker forward progress. The block also tracks a write epoch so the checker can detect that the board changed mid-scan and restart. It sits between both requesters and a synchronous single-port RAM with 1-cycle read latency.

Parameters:
ADDR_W, 2, row address width (4 rows)
DATA_W, 16, row word width (4 cells x 4-bit value)
MAX_STREAK, 3, max consecutive controller grants while checker waits
EPOCH_W, 4, write-epoch counter width

Ports:
CLK  in  1  system clock, all state on rising edge
RST  in  1  asynchronous active-low reset
c_req  in  1  controller access request, held until c_gnt
c_we  in  1  controller write (1) / read (0), valid with c_req
c_addr  in  ADDR_W  controller row address
c_wdata  in  DATA_W  controller write data
c_gnt  out  1  controller access accepted this cycle
c_rvalid  out  1  controller read data valid
c_rdata  out  DATA_W  controller read data
k_req  in  1  checker read request, held until k_gnt
k_addr  in  ADDR_W  checker row address
k_gnt  out  1  checker access accepted this cycle
k_rvalid  out  1  checker read data valid
k_rdata  out  DATA_W  checker read data
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_wren  out  1  RAM write enable
ram_q  in  DATA_W  RAM read data, 1 cycle after address
epoch  out  EPOCH_W  count of granted controller writes
busy_c  out  1  controller owns the RAM this cycle (debug)

Behaviour:
- Reset (RST=0, async): streak=0, epoch=0, rd_owner=NONE, c_rvalid=k_rvalid=0, c_rdata=k_rdata=0. Grants are 0 while RST=0.
- Grants are combinational from the current req and the registered streak; at most one grant per cycle.
- Arbitration:
  - c_req && !k_req -> c_gnt.
  - k_req && !c_req -> k_gnt.
  - Both requesting: c_gnt if streak < MAX_STREAK, else k_gnt.
- streak:
  - +1 on each c_gnt while k_req=1, saturating at MAX_STREAK.
  - Clears to 0 on any k_gnt, or any cycle k_req=0.
- RAM drive:
  - On c_gnt: ram_addr=c_addr, ram_wren=c_we, ram_wdata=c_wdata.
  - On k_gnt: ram_addr=k_addr, ram_wren=0.
  - No grant: ram_wren=0; ram_addr holds its last value (registered shadow); ram_wdata=0.
- Read return:
  - rd_owner register captures C (c_gnt && !c_we), K (k_gnt), or NONE each cycle.
  - Next cycle: owner C -> c_rvalid=1 and c_rdata=ram_q; owner K -> k_rvalid=1 and k_rdata=ram_q.
  - rvalid is a 1-cycle pulse. rdata is registered from ram_q in the same cycle rvalid asserts and holds until the next read for that owner.
- Writes produce no rvalid. Each write increments epoch on the grant edge; epoch wraps 2^EPOCH_W-1 -> 0.
- Back-to-back: a new grant is allowed every cycle, giving full pipelining; a read issued at cycle N returns at N+1 regardless of the grant at N+1.
- Read-after-write at the same address on consecutive cycles returns the new data; the RAM is write-first, and this holds by ordering.
- Reset mid-read: the pending rvalid is discarded and never asserted.
- A request withdrawn before grant is legal; no state changes.
- busy_c = c_gnt.

Decomposition:
- Shared package sudoku_pkg:
  - ROWS=4, CELL_W=4, ROW_W=16, ADDR_W=2.
  - Owner enum {OWN_NONE, OWN_C, OWN_K}.
- One natural sub-module: sudoku_streak_limiter, containing the streak counter and priority decision, with outputs sel_c and sel_k.
- The read-return steering and epoch counter stay in the top level.

Test Plan:
- Reset: hold RST=0 with c_req=k_req=1 -> no grants, ram_wren=0, epoch=0, both rvalid=0. Release -> c_gnt first.
- Controller read: c_req=1, c_we=0, c_addr=2, RAM row2=16'h1234 -> c_gnt@N, c_rvalid@N+1, c_rdata=16'h1234, k_rvalid=0.
- Starvation: c_req and k_req held high continuously, MAX_STREAK=3 -> grant pattern C,C,C,K,C,C,C,K; k_rvalid one cycle after each k_gnt.
- Write/epoch: 17 controller writes with EPOCH_W=4 -> epoch ends at 1 (wrap), ram_wren high exactly 17 cycles, no c_rvalid.
- Read-after-write: write row1=16'h4321 @N, checker read row1 @N+1 -> k_rdata=16'h4321 @N+2.
- Async reset mid-read: k_gnt@N, RST low between edges -> k_rvalid stays 0, epoch=0, streak=0.
